sort_arbiter: RTL and testbench

SORT_ARBITER -- requirements
Module: sort_arbiter

---
 rtl/sort_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sort_arbiter.sv | 548 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_arbiter.sv
// sort_arbiter: two-requester round-robin front end for a packet sorter.
// A requester wins a grant with val && sop, streams its packet through a
// one-cycle register into the sorter, and the arbiter then waits until the
// sorter has emitted the sorted packet (srt_val_i && srt_eop_i) before
// granting again. The sorted stream is re-registered and tagged with id_o,
// the owner of the packet.
//
// Ports:
//   clk_i, srst_i               clock, asynchronous active-high reset
//   val/sop/eop/data{0,1}_i     requester packet streams
//   ready{0,1}_o                word accepted when val && ready
//   srt_{val,sop,eop,data}_o    stream into the sorter (registered)
//   srt_{val,sop,eop,data}_i    sorted stream from the sorter
//   srt_busy_i                  sorter busy, blocks new grants
//   {val,sop,eop,data}_o, id_o  sorted stream, one register after srt_*_i
//   busy_o                      arbiter not idle
//   err_o                       one-cycle pulse on a truncated packet
//
// Optional feature: define SORT_ARB_LEN_GUARD_EN to cut packets at
// 2**AWIDTH words (forced eop, err_o pulse, remainder drained).
module sort_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 9
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              val0_i,
  input  logic              sop0_i,
  input  logic              eop0_i,
  input  logic [DWIDTH-1:0] data0_i,
  output logic              ready0_o,
  input  logic              val1_i,
  input  logic              sop1_i,
  input  logic              eop1_i,
  input  logic [DWIDTH-1:0] data1_i,
  output logic              ready1_o,
  output logic              srt_val_o,
  output logic              srt_sop_o,
  output logic              srt_eop_o,
  output logic [DWIDTH-1:0] srt_data_o,
  input  logic              srt_val_i,
  input  logic              srt_sop_i,
  input  logic              srt_eop_i,
  input  logic [DWIDTH-1:0] srt_data_i,
  input  logic              srt_busy_i,
  output logic              val_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              id_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, FWD, DRAIN, WAIT} state_t;

  state_t state, state_nxt;

  logic              gnt;       // owner of the current packet
  logic              last;      // port served last, for round-robin ties
  logic              first_p0;  // next forwarded word is the packet head
  logic              req0, req1, pick, start;
  logic              sel_val, sel_eop;
  logic [DWIDTH-1:0] sel_data;
  logic              active, acc, fwd_acc, trunc;

  logic              srt_val_p0, srt_sop_p0, srt_eop_p0;
  logic [DWIDTH-1:0] srt_data_p0;
  logic              val_p1, sop_p1, eop_p1;
  logic [DWIDTH-1:0] data_p1;

  assign req0 = val0_i & sop0_i;
  assign req1 = val1_i & sop1_i;

  // Tie goes to the port not served last; a lone request simply wins.
  always_comb begin
    if (req0 && req1) pick = ~last;
    else              pick = ~req0;
  end

  assign start    = (state == IDLE) && (req0 || req1) && !srt_busy_i;
  assign sel_val  = gnt ? val1_i  : val0_i;
  assign sel_eop  = gnt ? eop1_i  : eop0_i;
  assign sel_data = gnt ? data1_i : data0_i;
  assign active   = (state == FWD) || (state == DRAIN);
  assign acc      = active && sel_val;
  assign fwd_acc  = acc && (state == FWD);

`ifdef SORT_ARB_LEN_GUARD_EN
  logic [AWIDTH:0] cnt;
  logic            err_p0;

  // cnt holds the number of words already forwarded, so this fires on the
  // 2**AWIDTH-th word when it does not carry its own eop.
  assign trunc = fwd_acc && !sel_eop && (cnt == {1'b0, {AWIDTH{1'b1}}});

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt    <= '0;
      err_p0 <= 1'b0;
    end else begin
      err_p0 <= trunc;
      if (start)        cnt <= '0;
      else if (fwd_acc) cnt <= cnt + 1'b1;
    end
  end

  assign err_o = err_p0;
`else
  wire [AWIDTH:0] unused_len = '0;

  assign trunc = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FWD;
      FWD: begin
        if (acc && sel_eop) state_nxt = WAIT;
        else if (trunc)     state_nxt = DRAIN;
      end
      DRAIN:   if (acc && sel_eop) state_nxt = WAIT;
      WAIT:    if (srt_val_i && srt_eop_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready0_o = 1'b0;
    ready1_o = 1'b0;
    busy_o   = (state != IDLE);
    if (active) begin
      ready0_o = ~gnt;
      ready1_o = gnt;
    end
  end

  // Stage p0: accepted word registered toward the sorter
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      srt_val_p0  <= 1'b0;
      srt_sop_p0  <= 1'b0;
      srt_eop_p0  <= 1'b0;
      srt_data_p0 <= '0;
      first_p0    <= 1'b0;
      gnt         <= 1'b0;
      last        <= 1'b1;
    end else begin
      srt_val_p0 <= fwd_acc;
      // sop is regenerated from packet position, masking repeats mid-packet
      srt_sop_p0 <= fwd_acc && first_p0;
      srt_eop_p0 <= fwd_acc && (sel_eop || trunc);
      if (fwd_acc) begin
        srt_data_p0 <= sel_data;
        first_p0    <= 1'b0;
      end
      if (start) begin
        gnt      <= pick;
        last     <= pick;
        first_p0 <= 1'b1;
      end
    end
  end

  // Stage p1: sorted stream from the sorter re-registered
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      val_p1  <= 1'b0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      val_p1  <= srt_val_i;
      sop_p1  <= srt_sop_i;
      eop_p1  <= srt_eop_i;
      data_p1 <= srt_data_i;
    end
  end

  assign srt_val_o  = srt_val_p0;
  assign srt_sop_o  = srt_sop_p0;
  assign srt_eop_o  = srt_eop_p0;
  assign srt_data_o = srt_data_p0;
  assign val_o      = val_p1;
  assign sop_o      = sop_p1;
  assign eop_o      = eop_p1;
  assign data_o     = data_p1;
  // The grant register keeps the owner until the next grant, which cannot
  // happen before the sorted eop has been registered.
  assign id_o       = gnt;

endmodule

// File: tb/tb_sort_arbiter.sv
// Testbench for sort_arbiter: a behavioural sorter answers the srt_* stream,
// expected forwarded and sorted words are queued when stimulus is issued and
// compared against what the monitor captures.
module tb_sort_arbiter;

  logic       clk = 1'b0;
  logic       srst;
  logic       val0, sop0, eop0, ready0;
  logic [7:0] data0;
  logic       val1, sop1, eop1, ready1;
  logic [7:0] data1;
  logic       srt_val, srt_sop, srt_eop;
  logic [7:0] srt_data;
  logic       srt_val_in = 1'b0, srt_sop_in = 1'b0, srt_eop_in = 1'b0;
  logic [7:0] srt_data_in = 8'h00;
  logic       srt_busy;
  logic       val, sop, eop, id, busy, err;
  logic [7:0] data;

  int compared = 0;
  int mismatched = 0;
  int err_cnt = 0;
  bit abort = 1'b0;
  logic busy_force = 1'b0;

  logic [9:0]  srt_q[$];
  logic [9:0]  exp_srt[$];
  logic [10:0] out_q[$];
  logic [10:0] exp_out[$];

  logic [7:0] sbuf[$];
  logic [7:0] semit[$];
  int   sdelay = 0;
  int   sj;
  bit   sfirst = 1'b0;
  logic mbusy = 1'b0;

  assign srt_busy = mbusy | busy_force;

  sort_arbiter #(.DWIDTH(8), .AWIDTH(3)) dut (
    .clk_i(clk), .srst_i(srst),
    .val0_i(val0), .sop0_i(sop0), .eop0_i(eop0), .data0_i(data0), .ready0_o(ready0),
    .val1_i(val1), .sop1_i(sop1), .eop1_i(eop1), .data1_i(data1), .ready1_o(ready1),
    .srt_val_o(srt_val), .srt_sop_o(srt_sop), .srt_eop_o(srt_eop), .srt_data_o(srt_data),
    .srt_val_i(srt_val_in), .srt_sop_i(srt_sop_in), .srt_eop_i(srt_eop_in),
    .srt_data_i(srt_data_in), .srt_busy_i(srt_busy),
    .val_o(val), .sop_o(sop), .eop_o(eop), .data_o(data), .id_o(id),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // Behavioural sorter: collects a packet, then emits it ascending after a
  // short latency, holding busy meanwhile.
  always @(negedge clk) begin
    if (srst) begin
      sbuf.delete();
      semit.delete();
      mbusy = 1'b0;
      srt_val_in = 1'b0;
      srt_sop_in = 1'b0;
      srt_eop_in = 1'b0;
    end else begin
      srt_val_in = 1'b0;
      srt_sop_in = 1'b0;
      srt_eop_in = 1'b0;
      if (semit.size() > 0) begin
        if (sdelay > 0) sdelay--;
        else begin
          srt_val_in  = 1'b1;
          srt_sop_in  = sfirst;
          srt_data_in = semit.pop_front();
          srt_eop_in  = (semit.size() == 0);
          sfirst = 1'b0;
          if (semit.size() == 0) mbusy = 1'b0;
        end
      end
      if (srt_val) begin
        sbuf.push_back(srt_data);
        if (srt_eop) begin
          semit.delete();
          foreach (sbuf[k]) begin
            sj = 0;
            while (sj < semit.size() && semit[sj] <= sbuf[k]) sj++;
            semit.insert(sj, sbuf[k]);
          end
          sbuf.delete();
          mbusy = 1'b1;
          sdelay = 2;
          sfirst = 1'b1;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (srt_val) srt_q.push_back({srt_sop, srt_eop, srt_data});
    if (val) out_q.push_back({id, sop, eop, data});
    if (err) err_cnt++;
  end

  function automatic logic [26:0] outs();
    return {ready0, ready1, srt_val, srt_sop, srt_eop, srt_data,
            val, sop, eop, data, id, busy, err};
  endfunction

  task automatic clear_sb();
    srt_q.delete();
    out_q.delete();
    exp_srt.delete();
    exp_out.delete();
  endtask

  task automatic set_port(input int p, input logic v, input logic s, input logic e,
                          input logic [7:0] d);
    if (p == 0) begin val0 = v; sop0 = s; eop0 = e; data0 = d; end
    else        begin val1 = v; sop1 = s; eop1 = e; data1 = d; end
  endtask

  // Expected forwarded stream (first f words, eop on word f) and its sorted
  // counterpart tagged with the owning port.
  task automatic push_exp(input logic p, input logic [7:0] w[$], input int f);
    logic [7:0] s[$];
    int j;
    for (int i = 0; i < f; i++) begin
      exp_srt.push_back({i == 0, i == f - 1, w[i]});
      j = 0;
      while (j < s.size() && s[j] <= w[i]) j++;
      s.insert(j, w[i]);
    end
    for (int i = 0; i < f; i++) exp_out.push_back({p, i == 0, i == f - 1, s[i]});
  endtask

  task automatic drive_pkt(input int p, input logic [7:0] w[$], input int gap_at,
                           input int gap_len, output bit ok);
    int i = 0;
    int gap = 0;
    int guard = 0;
    logic rdy;
    ok = 1'b1;
    while (i < w.size()) begin
      @(negedge clk);
      if (abort) break;
      guard++;
      if (guard > 400) begin ok = 1'b0; break; end
      if (i == gap_at && gap < gap_len) begin
        gap++;
        set_port(p, 1'b0, 1'b0, 1'b0, 8'h00);
        continue;
      end
      set_port(p, 1'b1, i == 0, i == w.size() - 1, w[i]);
      rdy = (p == 0) ? ready0 : ready1;
      if (rdy) i++;
    end
    if (i == w.size()) @(negedge clk);
    set_port(p, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_done();
    int n = 0;
    while (out_q.size() < exp_out.size() && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (outs() !== 27'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h required 0", outs());
    end
    @(negedge clk);
    srst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (outs() !== 27'h0) begin
      mismatched++;
      $display("FAIL idle_outputs: got %h required 0", outs());
    end
  endtask

  task automatic test_single();
    logic [7:0] w[$];
    bit ok;
    clear_sb();
    w = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    push_exp(1'b0, w, 5);
    drive_pkt(0, w, -1, 0, ok);
    wait_done();
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL single_handshake: got %0b required 1", ok); end
    compared++;
    if (srt_q.size() != exp_srt.size()) begin
      mismatched++;
      $display("FAIL single_srt_count: got %0d required %0d", srt_q.size(), exp_srt.size());
    end
    for (int k = 0; k < exp_srt.size() && k < srt_q.size(); k++) begin
      compared++;
      if (srt_q[k] !== exp_srt[k]) begin
        mismatched++;
        $display("FAIL single_srt[%0d]: got %h required %h", k, srt_q[k], exp_srt[k]);
      end
    end
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL single_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL single_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_tie();
    logic [7:0] w0[$];
    logic [7:0] w1[$];
    bit ok0, ok1;
    int bad = 0;
    clear_sb();
    w0 = '{8'd20, 8'd10, 8'd30};
    w1 = '{8'd6, 8'd5, 8'd4, 8'd7};
    push_exp(1'b0, w0, 3);
    push_exp(1'b1, w1, 4);
    fork
      drive_pkt(0, w0, -1, 0, ok0);
      drive_pkt(1, w1, -1, 0, ok1);
      begin
        int n = 0;
        while (out_q.size() < 3 && n < 400) begin
          @(negedge clk); #1;
          if (ready1 !== 1'b0) bad++;
          n++;
        end
      end
    join
    wait_done();
    compared++;
    if ({ok0, ok1} !== 2'b11) begin mismatched++; $display("FAIL tie_handshake: got %b required 11", {ok0, ok1}); end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL tie_ready1_early: got %0d cycles required 0", bad); end
    compared++;
    if (srt_q.size() != exp_srt.size()) begin
      mismatched++;
      $display("FAIL tie_srt_count: got %0d required %0d", srt_q.size(), exp_srt.size());
    end
    for (int k = 0; k < exp_srt.size() && k < srt_q.size(); k++) begin
      compared++;
      if (srt_q[k] !== exp_srt[k]) begin
        mismatched++;
        $display("FAIL tie_srt[%0d]: got %h required %h", k, srt_q[k], exp_srt[k]);
      end
    end
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL tie_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL tie_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
    // Port 1 was served last, so the next tie goes back to port 0.
    clear_sb();
    w0 = '{8'd2, 8'd1};
    w1 = '{8'd9, 8'd8};
    push_exp(1'b0, w0, 2);
    push_exp(1'b1, w1, 2);
    fork
      drive_pkt(0, w0, -1, 0, ok0);
      drive_pkt(1, w1, -1, 0, ok1);
    join
    wait_done();
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL tie2_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL tie2_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] w0[$];
    logic [7:0] w1[$];
    bit ok0, ok1;
    clear_sb();
    w0 = '{8'd5, 8'd6};
    push_exp(1'b0, w0, 2);
    drive_pkt(0, w0, -1, 0, ok0);
    wait_done();
    // Port 0 served last: the tie now goes to port 1.
    w0 = '{8'd44, 8'd33};
    w1 = '{8'd12, 8'd11, 8'd13};
    push_exp(1'b1, w1, 3);
    push_exp(1'b0, w0, 2);
    fork
      drive_pkt(0, w0, -1, 0, ok0);
      drive_pkt(1, w1, -1, 0, ok1);
    join
    wait_done();
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL rr_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL rr_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] w[$];
    bit ok;
    clear_sb();
    w = '{8'd40, 8'd12, 8'd33, 8'd7, 8'd21, 8'd2};
    push_exp(1'b0, w, 6);
    drive_pkt(0, w, 2, 3, ok);
    wait_done();
    compared++;
    if (srt_q.size() != exp_srt.size()) begin
      mismatched++;
      $display("FAIL gap_srt_count: got %0d required %0d", srt_q.size(), exp_srt.size());
    end
    for (int k = 0; k < exp_srt.size() && k < srt_q.size(); k++) begin
      compared++;
      if (srt_q[k] !== exp_srt[k]) begin
        mismatched++;
        $display("FAIL gap_srt[%0d]: got %h required %h", k, srt_q[k], exp_srt[k]);
      end
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL gap_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_length();
    logic [7:0] w[$];
    bit ok;
    int f;
    int exp_err;
    int err0;
`ifdef SORT_ARB_LEN_GUARD_EN
    f = 8;
    exp_err = 1;
`else
    f = 11;
    exp_err = 0;
`endif
    clear_sb();
    w = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd15, 8'd10, 8'd5};
    push_exp(1'b1, w, f);
    err0 = err_cnt;
    drive_pkt(1, w, -1, 0, ok);
    wait_done();
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL len_handshake: got %0b required 1", ok); end
    compared++;
    if (err_cnt - err0 != exp_err) begin
      mismatched++;
      $display("FAIL len_err_cycles: got %0d required %0d", err_cnt - err0, exp_err);
    end
    compared++;
    if (srt_q.size() != exp_srt.size()) begin
      mismatched++;
      $display("FAIL len_srt_count: got %0d required %0d", srt_q.size(), exp_srt.size());
    end
    for (int k = 0; k < exp_srt.size() && k < srt_q.size(); k++) begin
      compared++;
      if (srt_q[k] !== exp_srt[k]) begin
        mismatched++;
        $display("FAIL len_srt[%0d]: got %h required %h", k, srt_q[k], exp_srt[k]);
      end
    end
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL len_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL len_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w[$];
    bit ok;
    clear_sb();
    w = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    fork
      drive_pkt(0, w, -1, 0, ok);
      begin
        int n = 0;
        while (srt_q.size() < 1 && n < 100) begin
          @(negedge clk); #1;
          n++;
        end
        #1 srst = 1'b1;
        abort = 1'b1;
        #1;
        compared++;
        if (outs() !== 27'h0) begin
          mismatched++;
          $display("FAIL midreset_outputs: got %h required 0", outs());
        end
      end
    join
    repeat (2) @(negedge clk);
    srst = 1'b0;
    abort = 1'b0;
    clear_sb();
    @(negedge clk); #1;
    compared++;
    if (busy !== 1'b0 || srt_val !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_release: got busy=%b srt_val=%b required 0/0", busy, srt_val);
    end
    w = '{8'd4, 8'd2, 8'd8, 8'd6};
    push_exp(1'b1, w, 4);
    drive_pkt(1, w, -1, 0, ok);
    wait_done();
    compared++;
    if (srt_q.size() != exp_srt.size()) begin
      mismatched++;
      $display("FAIL midreset_srt_count: got %0d required %0d", srt_q.size(), exp_srt.size());
    end
    for (int k = 0; k < exp_srt.size() && k < srt_q.size(); k++) begin
      compared++;
      if (srt_q[k] !== exp_srt[k]) begin
        mismatched++;
        $display("FAIL midreset_srt[%0d]: got %h required %h", k, srt_q[k], exp_srt[k]);
      end
    end
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL midreset_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL midreset_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_busy();
    logic [7:0] w[$];
    bit ok;
    int bad = 0;
    clear_sb();
    // val without sop is not a request
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 1'b0, 8'hAA);
    repeat (4) begin
      @(negedge clk); #1;
      if (ready1 !== 1'b0 || busy !== 1'b0) bad++;
    end
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL nosop_request: got %0d granted cycles required 0", bad); end
    // request held off while the sorter reports busy
    bad = 0;
    busy_force = 1'b1;
    w = '{8'd3, 8'd1, 8'd2};
    push_exp(1'b0, w, 3);
    fork
      drive_pkt(0, w, -1, 0, ok);
      begin
        repeat (6) begin
          @(negedge clk); #1;
          if (ready0 !== 1'b0 || busy !== 1'b0) bad++;
        end
        busy_force = 1'b0;
      end
    join
    wait_done();
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL busy_holdoff: got %0d granted cycles required 0", bad); end
    compared++;
    if (out_q.size() != exp_out.size()) begin
      mismatched++;
      $display("FAIL busy_out_count: got %0d required %0d", out_q.size(), exp_out.size());
    end
    for (int k = 0; k < exp_out.size() && k < out_q.size(); k++) begin
      compared++;
      if (out_q[k] !== exp_out[k]) begin
        mismatched++;
        $display("FAIL busy_out[%0d]: got %h required %h", k, out_q[k], exp_out[k]);
      end
    end
  endtask

  initial begin
    srst = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    test_reset();
    test_tie();
    test_single();
    test_round_robin();
    test_gap();
    test_length();
    test_reset_mid();
    test_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
